// File: rtl/lsu_bus_sequencer_pkg.sv
// Shared types and constants for the LSU bus sequencer: FSM states,
// funct3 memory access encodings, the full-word byte-enable mask and the
// write-side bus payload.
package lsu_bus_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] MEM_LB  = 3'b000;
  localparam logic [2:0] MEM_LH  = 3'b001;
  localparam logic [2:0] MEM_LW  = 3'b010;
  localparam logic [2:0] MEM_LBU = 3'b100;
  localparam logic [2:0] MEM_LHU = 3'b101;
  localparam logic [2:0] MEM_SB  = 3'b000;
  localparam logic [2:0] MEM_SH  = 3'b001;
  localparam logic [2:0] MEM_SW  = 3'b010;

  localparam logic [3:0] BUS_BE_WORD = 4'b1111;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } lsu_wr_payload_t;

  // Halfword accesses need addr[0]=0, word accesses need addr[1:0]=0.
  // Store encodings alias the load ones, so LH/LHU/LW cover SH/SW too.
  function automatic logic is_misaligned(input logic [2:0] mem_type,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (mem_type)
      MEM_LH, MEM_LHU: mis = addr_lo[0];
      MEM_LW:          mis = (addr_lo != 2'b00);
      default:         mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_bus_sequencer_timeout_counter.sv
// Cycle counter bounding a bus transaction; expired_c rises once the count
// reaches TIMEOUT_CYCLES-1.
module lsu_bus_sequencer_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q;

  // Clear on transaction start, count while the bus is busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/lsu_bus_sequencer.sv
// Memory-access stage: runs one request/grant/response bus transaction per
// load or store and stalls the core until it finishes.
// Optional build macro LSU_MISALIGN_CHECK_EN aborts misaligned halfword/word
// accesses with a bus error without touching the bus.
module lsu_bus_sequencer
  import lsu_bus_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [2:0]        i_mem_type,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_store_data,
  input  logic [3:0]        i_byte_enable,
  output logic              o_stall,
  output logic [31:0]       o_rdata,
  output logic              o_done,
  output logic              o_bus_err,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [31:0]       o_bus_wdata,
  output logic [3:0]        o_bus_be,
  input  logic              i_bus_gnt,
  input  logic              i_bus_rvalid,
  input  logic [31:0]       i_bus_rdata
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:2] addr_q;
  lsu_wr_payload_t   wr_q;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic start_c, misalign_c, expired_c;
  logic cnt_clr_c, cnt_en_c, load_req_c, finish_c, in_addr_c;

  assign start_c = i_valid & (i_mem_read | i_mem_write);

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign_c = is_misaligned(i_mem_type, i_addr[1:0]);
`else
  assign misalign_c = 1'b0;
`endif

  // Low address bits and access type only matter to the alignment check.
  logic unused_lo_bits;
  assign unused_lo_bits = ^{i_mem_type, i_addr[1:0]};

  lsu_bus_sequencer_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clr_c),
    .enable   (cnt_en_c),
    .expired_c(expired_c)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a same-cycle response beats the timeout.
  always_comb begin
    state_d    = state_q;
    load_req_c = 1'b0;
    finish_c   = 1'b0;
    err_d      = 1'b0;
    rdata_d    = '0;
    cnt_clr_c  = 1'b0;
    cnt_en_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_c) begin
          if (misalign_c) begin
            state_d  = DONE;
            finish_c = 1'b1;
            err_d    = 1'b1;
          end else begin
            state_d    = ADDR;
            load_req_c = 1'b1;
            cnt_clr_c  = 1'b1;
          end
        end
      end
      ADDR: begin
        cnt_en_c = 1'b1;
        if (i_bus_gnt && i_bus_rvalid) begin
          state_d  = DONE;
          finish_c = 1'b1;
          rdata_d  = wr_q.we ? 32'h0 : i_bus_rdata;
        end else if (expired_c) begin
          state_d  = DONE;
          finish_c = 1'b1;
          err_d    = 1'b1;
        end else if (i_bus_gnt) begin
          state_d = RESP;
        end
      end
      RESP: begin
        cnt_en_c = 1'b1;
        if (i_bus_rvalid) begin
          state_d  = DONE;
          finish_c = 1'b1;
          rdata_d  = wr_q.we ? 32'h0 : i_bus_rdata;
        end else if (expired_c) begin
          state_d  = DONE;
          finish_c = 1'b1;
          err_d    = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the request at start; reads always use all four lanes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      wr_q   <= '0;
    end else if (load_req_c) begin
      addr_q      <= i_addr[ADDR_W-1:2];
      wr_q.we     <= ~i_mem_read;
      wr_q.be     <= i_mem_read ? BUS_BE_WORD : i_byte_enable;
      wr_q.wdata  <= i_store_data;
    end
  end

  // Capture the transaction result on the way into DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (finish_c) begin
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign in_addr_c   = (state_q == ADDR);
  assign o_stall     = ((state_q == IDLE) && start_c) || in_addr_c || (state_q == RESP);
  assign o_bus_req   = in_addr_c;
  assign o_bus_we    = in_addr_c & wr_q.we;
  assign o_bus_be    = in_addr_c ? wr_q.be : 4'h0;
  assign o_bus_wdata = in_addr_c ? wr_q.wdata : 32'h0;
  assign o_bus_addr  = in_addr_c ? {addr_q, 2'b00} : '0;
  assign o_done      = (state_q == DONE);
  assign o_rdata     = o_done ? rdata_q : 32'h0;
  assign o_bus_err   = o_done & err_q;

endmodule

// File: tb/tb_lsu_bus_sequencer.sv
// Randomized self-checking bench for lsu_bus_sequencer. Expected timing and
// data per transaction come from a cycle-offset model of the bus protocol.
module tb_lsu_bus_sequencer;

  localparam int T = 16;
`ifdef LSU_MISALIGN_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_mem_read, i_mem_write;
  logic [2:0]  i_mem_type;
  logic [31:0] i_addr, i_store_data;
  logic [3:0]  i_byte_enable;
  logic        o_stall, o_done, o_bus_err, o_bus_req, o_bus_we;
  logic [31:0] o_rdata, o_bus_addr, o_bus_wdata;
  logic [3:0]  o_bus_be;
  logic        i_bus_gnt, i_bus_rvalid;
  logic [31:0] i_bus_rdata;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  lsu_bus_sequencer #(.TIMEOUT_CYCLES(T), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_mem_read(i_mem_read),
    .i_mem_write(i_mem_write), .i_mem_type(i_mem_type), .i_addr(i_addr),
    .i_store_data(i_store_data), .i_byte_enable(i_byte_enable),
    .o_stall(o_stall), .o_rdata(o_rdata), .o_done(o_done), .o_bus_err(o_bus_err),
    .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
    .o_bus_wdata(o_bus_wdata), .o_bus_be(o_bus_be), .i_bus_gnt(i_bus_gnt),
    .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata)
  );

  always #5 clk = ~clk;

  function automatic bit model_misaligned(input logic [2:0] mt, input logic [31:0] a);
    bit half, word;
    half = (mt == 3'd1) || (mt == 3'd5);
    word = (mt == 3'd2);
    return (half && a[0]) || (word && (a[1:0] != 2'b00));
  endfunction

  // One memory op: rel counts cycles from the start cycle (rel=0). The bus
  // responder grants g cycles into the request and answers r cycles later.
  task automatic run_op(input bit rd, input bit wr, input logic [2:0] mt,
                        input logic [31:0] a, input logic [31:0] sd, input logic [3:0] be,
                        input int g, input int r, input logic [31:0] rdat,
                        input int tail, input string tag);
    int done_off, last, gnt_rel;
    bit skip, err_exp, we_exp, exp_req;
    logic [31:0] rdata_exp;
    logic [3:0]  be_exp, got4, want4;
    logic [68:0] got_bus, want_bus;
    skip   = CHECK_EN && model_misaligned(mt, a);
    we_exp = !rd;
    be_exp = rd ? 4'hF : be;
    if (skip) begin
      done_off = 1; err_exp = 1'b1; rdata_exp = 32'h0;
    end else if (g + r <= T - 1) begin
      done_off = g + r + 2; err_exp = 1'b0; rdata_exp = rd ? rdat : 32'h0;
    end else begin
      done_off = T + 1; err_exp = 1'b1; rdata_exp = 32'h0;
    end
    last = done_off + tail;
    if (tail > 0 && !skip && (2 + g + r) > last && (2 + g + r) < 60) last = 2 + g + r;
    gnt_rel = -1;
    for (int rel = 0; rel <= last; rel++) begin
      @(negedge clk);
      i_valid       = (rel <= done_off);
      i_mem_read    = rd;
      i_mem_write   = wr;
      i_mem_type    = mt;
      i_addr        = a;
      i_store_data  = sd;
      i_byte_enable = be;
      i_bus_gnt     = 1'b0;
      i_bus_rvalid  = 1'b0;
      i_bus_rdata   = $urandom();
      #1;
      exp_req = !skip && rel >= 1 && rel <= 1 + g && rel < done_off;
      got4  = {o_stall, o_done, o_bus_req, o_bus_err};
      want4 = {rel < done_off, rel == done_off, exp_req, (rel == done_off) && err_exp};
      n_vec++;
      if (got4 !== want4) begin
        n_err++;
        $display("FAIL %s ctl rel=%0d {stall,done,req,err} got %b want %b", tag, rel, got4, want4);
      end
      if (exp_req) begin
        got_bus  = {o_bus_addr, o_bus_we, o_bus_be, (we_exp ? o_bus_wdata : 32'h0)};
        want_bus = {a & 32'hFFFF_FFFC, we_exp, be_exp, (we_exp ? sd : 32'h0)};
        n_vec++;
        if (got_bus !== want_bus) begin
          n_err++;
          $display("FAIL %s bus rel=%0d {addr,we,be,wdata} got %h want %h", tag, rel, got_bus, want_bus);
        end
      end
      if (rel == done_off) begin
        n_vec++;
        if (o_rdata !== rdata_exp) begin
          n_err++;
          $display("FAIL %s rdata got %h want %h", tag, o_rdata, rdata_exp);
        end
      end
      if (o_bus_req && rel == 1 + g) begin
        i_bus_gnt = 1'b1;
        gnt_rel   = rel;
      end
      if (gnt_rel >= 0 && rel == gnt_rel + r) begin
        i_bus_rvalid = 1'b1;
        i_bus_rdata  = rdat;
      end
    end
    @(negedge clk);
    i_valid = 1'b0; i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_valid = 0; i_mem_read = 0; i_mem_write = 0; i_mem_type = 0; i_addr = 0;
    i_store_data = 0; i_byte_enable = 0; i_bus_gnt = 0; i_bus_rvalid = 0; i_bus_rdata = 0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({o_stall, o_done, o_bus_err, o_bus_req, o_bus_we, o_bus_be, o_bus_addr, o_bus_wdata, o_rdata} !== '0) begin
      n_err++;
      $display("FAIL reset outputs got stall=%b done=%b req=%b addr=%h rdata=%h want all 0",
               o_stall, o_done, o_bus_req, o_bus_addr, o_rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_lw();
    run_op(1, 0, 3'd2, 32'h0000_0104, 32'h0, 4'h0, 0, 0, 32'hDEAD_BEEF, 1, "lw_104");
  endtask

  task automatic test_sb();
    run_op(0, 1, 3'd0, 32'h0000_0203, 32'hAB00_0000, 4'b1000, 3, 2, 32'h1234_5678, 1, "sb_203");
  endtask

  task automatic test_timeout();
    run_op(1, 0, 3'd2, 32'h0000_0300, 32'h0, 4'h0, 0, 30, 32'hCAFE_F00D, 2, "timeout_resp");
    run_op(0, 1, 3'd2, 32'h0000_0400, 32'h5555_AAAA, 4'hF, 25, 0, 32'h0, 1, "timeout_addr");
    run_op(1, 0, 3'd2, 32'h0000_0500, 32'h0, 4'h0, 0, T - 1, 32'h0BAD_CAFE, 1, "edge_last_cycle");
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    i_valid = 1; i_mem_read = 1; i_mem_write = 0; i_mem_type = 3'd2; i_addr = 32'h40;
    @(negedge clk);
    #1 i_bus_gnt = 1'b1;
    @(negedge clk);
    i_bus_gnt = 1'b0;
    #2;
    n_vec++;
    if ({o_stall, o_bus_req} !== 2'b10) begin
      n_err++;
      $display("FAIL arst_pre {stall,req} got %b want 10", {o_stall, o_bus_req});
    end
    rst = 1'b1; i_valid = 1'b0;
    #1;
    n_vec++;
    if ({o_stall, o_done, o_bus_req, o_bus_err, o_rdata} !== '0) begin
      n_err++;
      $display("FAIL arst_drop stall=%b done=%b req=%b err=%b want all 0", o_stall, o_done, o_bus_req, o_bus_err);
    end
    @(negedge clk);
    rst = 1'b0;
    i_bus_rvalid = 1'b1; i_bus_rdata = 32'hFFFF_0000;
    @(negedge clk);
    i_bus_rvalid = 1'b0;
    #1;
    n_vec++;
    if (o_done !== 1'b0) begin
      n_err++;
      $display("FAIL arst_late_rvalid done got %b want 0", o_done);
    end
    run_op(1, 0, 3'd2, 32'h0000_0044, 32'h0, 4'h0, 1, 1, 32'h7654_3210, 1, "arst_recover");
  endtask

  task automatic test_misalign();
    run_op(1, 0, 3'd1, 32'h0000_0011, 32'h0, 4'h0, 0, 0, 32'h0000_BEEF, 1, "lh_011");
    run_op(0, 1, 3'd2, 32'h0000_0022, 32'h1111_2222, 4'hF, 1, 0, 32'h0, 1, "sw_022");
  endtask

  task automatic test_rw_both();
    run_op(1, 1, 3'd2, 32'h0000_0608, 32'h9999_9999, 4'b0011, 1, 1, 32'h0F0F_0F0F, 1, "rw_both");
    @(negedge clk);
    i_valid = 1'b0; i_bus_rvalid = 1'b1; i_bus_rdata = 32'hABCD_EF01;
    #1;
    n_vec++;
    if ({o_done, o_stall} !== 2'b00) begin
      n_err++;
      $display("FAIL stray_rvalid_idle {done,stall} got %b want 00", {o_done, o_stall});
    end
    @(negedge clk);
    i_bus_rvalid = 1'b0;
    #1;
    n_vec++;
    if (o_done !== 1'b0) begin
      n_err++;
      $display("FAIL stray_rvalid_next done got %b want 0", o_done);
    end
  endtask

  task automatic test_back_to_back();
    run_op(1, 0, 3'd2, 32'h0000_0700, 32'h0, 4'h0, 0, 0, 32'h1111_1111, 0, "b2b_0");
    run_op(0, 1, 3'd1, 32'h0000_0702, 32'h2222_0000, 4'b1100, 0, 1, 32'h0, 0, "b2b_1");
    run_op(1, 0, 3'd4, 32'h0000_0703, 32'h0, 4'h0, 2, 0, 32'h3333_3333, 1, "b2b_2");
  endtask

  task automatic test_random();
    bit rd, wr;
    int g, r;
    logic [2:0] mt;
    logic [2:0] types [5];
    types[0] = 3'd0; types[1] = 3'd1; types[2] = 3'd2; types[3] = 3'd4; types[4] = 3'd5;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0: begin rd = 1; wr = 0; end
        1: begin rd = 0; wr = 1; end
        default: begin rd = 1; wr = 1; end
      endcase
      mt = types[$urandom_range(0, 4)];
      g  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 3));
      r  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 3));
      run_op(rd, wr, mt, $urandom(), $urandom(), 4'($urandom()), g, r, $urandom(),
             int'($urandom_range(0, 2)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sb();
    test_timeout();
    test_async_reset();
    test_misalign();
    test_rw_both();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_bus_sequencer.md
Name: lsu_bus_sequencer

Overview:
- Memory-access stage directly downstream of the execute/functional-unit stage.
- Takes the execute results for one load or store: ALU address, aligned store data, byte enables and read/write flags.
- Runs one request/grant/response transaction on the data bus and stalls the core until the transaction completes.
- Returns the raw 32-bit read word to the load-extraction path in execute (its mem-read-data input).

Parameters:
- TIMEOUT_CYCLES, 16: max cycles spent in ADDR+RESP before aborting with a bus error; must be >= 2.
- ADDR_W, 32: address width.

Ports:
- clk  input  1  core clock
- rst  input  1  reset, asynchronous, active-high
- i_valid  input  1  execute stage holds a valid instruction this cycle
- i_mem_read  input  1  instruction is a load
- i_mem_write  input  1  instruction is a store
- i_mem_type  input  3  funct3 access type (LB/LH/LW/LBU/LHU, SB/SH/SW)
- i_addr  input  ADDR_W  effective address (ALU result)
- i_store_data  input  32  lane-aligned store data
- i_byte_enable  input  4  store byte lanes
- o_stall  output  1  freeze PC and pipeline registers
- o_rdata  output  32  raw read word; valid when o_done=1
- o_done  output  1  one-cycle pulse: transaction finished
- o_bus_err  output  1  valid with o_done; timeout or misalign abort
- o_bus_req  output  1  bus request
- o_bus_we  output  1  1 = write
- o_bus_addr  output  ADDR_W  word-aligned address, [1:0]=2'b00
- o_bus_wdata  output  32  write data
- o_bus_be  output  4  byte enables; 4'b1111 on reads
- i_bus_gnt  input  1  request accepted this cycle
- i_bus_rvalid  input  1  response (read data or write ack)
- i_bus_rdata  input  32  read data, valid with i_bus_rvalid

Behaviour:
- Reset: state IDLE. All outputs 0, timeout counter 0, captured registers 0. Asynchronous; an abort mid-transaction drops o_bus_req immediately and ignores later responses.
- start = i_valid & (i_mem_read | i_mem_write) in IDLE. If both read and write are set, the read wins (o_bus_we=0).
- FSM states:
  - IDLE: on start, capture addr/wdata/be/we and go to ADDR. No start: stay.
  - ADDR: o_bus_req=1 and bus outputs driven from captured registers, held stable until gnt.
    - gnt & rvalid in the same cycle: go to DONE, capture rdata.
    - gnt only: go to RESP.
  - RESP: o_bus_req=0. On rvalid: capture i_bus_rdata (writes: capture 0) and go to DONE.
  - DONE: o_done=1 and o_rdata=captured data for exactly one cycle; o_stall=0 so the pipeline advances. Unconditionally return to IDLE.
- o_stall = (IDLE & start) | ADDR | RESP. The stall is combinational in the start cycle, so the instruction is held.
- Minimum latency: start cycle, then ADDR (gnt+rvalid), then DONE, i.e. the instruction retires 2 cycles after it arrives. Back-to-back memory ops each pay one IDLE start cycle.
- Timeout counter:
  - Clears on entering ADDR; increments each cycle in ADDR or RESP.
  - On reaching TIMEOUT_CYCLES-1 without completion: go to DONE with o_bus_err=1 and o_rdata=0.
  - Any in-flight response is discarded: rvalid outside ADDR/RESP is ignored.
- rvalid in IDLE or DONE: ignored, no state change.
- o_bus_err=0 whenever o_done=0.

Optional Feature:
- Macro LSU_MISALIGN_CHECK_EN.
- Defined:
  - In IDLE, a start with halfword access and addr[0]=1, or word access and addr[1:0]!=0, skips the bus entirely.
  - Next cycle is DONE with o_bus_err=1, o_rdata=0, o_bus_req never asserted.
- Undefined: no check. Address is word-aligned on the bus and lanes come from the captured byte enables.

Decomposition:
- Shared package (e.g. core_pkg): lsu_state_e enum {IDLE, ADDR, RESP, DONE}, mem_type funct3 constants (MEM_LB..MEM_SW), BUS_BE_WORD=4'b1111.
- One natural sub-module: lsu_timeout_counter (clear/enable/expired), instantiated once; the FSM stays in the top.

Test Plan:
- LW at 0x0000_0104, gnt+rvalid same cycle, rdata 0xDEAD_BEEF: o_bus_addr=0x104, be=1111, o_stall high 2 cycles, o_done pulse with o_rdata=0xDEADBEEF, bus_err=0.
- SB at 0x0000_0203, data 0xAB00_0000, be 1000: gnt after 3 cycles, rvalid 2 cycles later: o_bus_we=1, addr=0x200, be=1000, req held until gnt, done pulse, rdata=0.
- Read with gnt but no rvalid, TIMEOUT_CYCLES=16: done with bus_err=1 exactly 16 cycles after ADDR entry; late rvalid afterwards is ignored.
- Async rst asserted while in RESP: req/stall/done drop immediately; after release, a new LW completes normally.
- With LSU_MISALIGN_CHECK_EN defined, LH at 0x0000_0011: no o_bus_req, done+bus_err 1 cycle after start. Without it: bus access at 0x10.
- Read and write both set on one instruction: o_bus_we=0 (read performed); stray rvalid in IDLE: no o_done.
